// File: rtl/alu_out_buffer.sv
// -----------------------------------------------------------------------------
// alu_out_buffer
//
// Output queue for the ALU function units. It accepts one result per
// valid/ready handshake and works out zero/negative/overflow flags at push
// time. Each result is stored with its function code and flags in a small
// FIFO. The head entry goes to the write-back consumer through a second
// valid/ready pair, so consumer stalls do not hold up the ALU.
//
// Parameters:
//   DATA_WIDTH  width of the result bus
//   DEPTH       number of FIFO entries (power of 2, >= 2)
//   CNT_W       occupancy counter width, derived from DEPTH
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid / in_ready          upstream handshake
//   in_result, in_func, in_of    result, function code and unit overflow
//   out_valid / out_ready        downstream handshake
//   out_result, out_func         head result and function code
//   out_zf, out_nf, out_of       head flags
//   count                        current occupancy, 0..DEPTH
//   sticky_of, sticky_clr        only with ALU_OUT_STICKY_OF_EN: latched
//                                "an overflowed result was consumed" flag
//                                and its clear input
//
// Configuration macro: ALU_OUT_STICKY_OF_EN. When it is undefined, the sticky
// ports and logic are absent.
// -----------------------------------------------------------------------------
module alu_out_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [3:0]            in_func,
    input  logic                  in_of,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [3:0]            out_func,
    output logic                  out_zf,
    output logic                  out_nf,
    output logic                  out_of,
`ifdef ALU_OUT_STICKY_OF_EN
    output logic                  sticky_of,
    input  logic                  sticky_clr,
`endif
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [3:0] FUNC_ZERO = 4'b1111;
    localparam logic [3:0] FUNC_TCP  = 4'b1110;

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    // The most negative value has no positive counterpart, so negating it
    // overflows.
    localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Returns the flags {zf, nf, of} for one incoming result.
    function automatic logic [2:0] derive_flags(
        input logic [DATA_WIDTH-1:0] result,
        input logic [3:0]            func,
        input logic                  unit_of
    );
        logic zf_v;
        logic nf_v;
        logic of_v;
        zf_v = (result == DATA_ZERO);
        nf_v = result[DATA_WIDTH-1];
        case (func)
            // ZERO always produces a clean zero, whatever is on the bus.
            FUNC_ZERO: begin
                zf_v = 1'b1;
                nf_v = 1'b0;
                of_v = 1'b0;
            end
            FUNC_TCP: begin
                of_v = unit_of | (result == MOST_NEG);
            end
            default: begin
                of_v = unit_of;
            end
        endcase
        return {zf_v, nf_v, of_v};
    endfunction

    logic [DATA_WIDTH-1:0] result_mem_r [DEPTH];
    logic [3:0]            func_mem_r   [DEPTH];
    logic [2:0]            flags_mem_r  [DEPTH];

    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;

    logic push_s;
    logic pop_s;

    // Full and empty come from the count alone, so in_ready never depends on
    // in_valid.
    assign in_ready  = (count_r != CNT_W'(DEPTH));
    assign out_valid = (count_r != {CNT_W{1'b0}});
    assign count     = count_r;

    assign push_s = in_valid && in_ready;
    assign pop_s  = out_valid && out_ready;

    // Pointer and occupancy state. The pointers wrap naturally because DEPTH
    // is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage. The contents do not matter until count marks a slot
    // valid, so this array has no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            result_mem_r[wptr_r] <= in_result;
            func_mem_r[wptr_r]   <= in_func;
            flags_mem_r[wptr_r]  <= derive_flags(in_result, in_func, in_of);
        end
    end

    // Head presentation. The fields are forced to zero while the queue is
    // empty.
    always_comb begin
        out_result = DATA_ZERO;
        out_func   = 4'b0000;
        out_zf     = 1'b0;
        out_nf     = 1'b0;
        out_of     = 1'b0;
        if (out_valid) begin
            out_result = result_mem_r[rptr_r];
            out_func   = func_mem_r[rptr_r];
            out_zf     = flags_mem_r[rptr_r][2];
            out_nf     = flags_mem_r[rptr_r][1];
            out_of     = flags_mem_r[rptr_r][0];
        end else begin
            out_result = DATA_ZERO;
        end
    end

`ifdef ALU_OUT_STICKY_OF_EN
    logic sticky_of_r;

    assign sticky_of = sticky_of_r;

    // Sticky overflow. A consumed overflow sets it, and the set takes
    // priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_of_r <= 1'b0;
        end else if (pop_s && out_of) begin
            sticky_of_r <= 1'b1;
        end else if (sticky_clr) begin
            sticky_of_r <= 1'b0;
        end else begin
            sticky_of_r <= sticky_of_r;
        end
    end
`endif

endmodule
